// File: rtl/uart_param.sv
// Single-clock UART: programmable width/parity/stop bits, 16x oversampled receiver
// with start-bit glitch rejection, frame/parity/overrun flags and load/unload handshake.
//
// TX state  | meaning
// ----------+-----------------------------------------------------------
// TX_IDLE   | line high, waiting for a loaded word and tx_enable
// TX_START  | driving the start bit (0)
// TX_DATA   | shifting data bits out, LSB first
// TX_PARITY | driving the parity bit (only when parity is enabled)
// TX_STOP   | driving STOP_BITS stop periods (1)
//
// RX state  | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | waiting for a synchronised high->low edge
// RX_START  | half-bit wait, then confirm start bit is still low
// RX_DATA   | sampling data bits at mid-bit
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the first stop bit and delivering the word
module uart_param #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 27,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_tx_data,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_enable,
   output logic                 tx_out,
   output logic                 tx_empty,
   input  logic                 uld_rx_data,
   input  logic                 rx_enable,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_empty,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int                BIT_CLKS  = 16 * BAUD_DIV;
   localparam int                TCNT_W    = $clog2(BIT_CLKS);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BIT_CLKS - 1);
   localparam int                PRE_W     = $clog2(BAUD_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(BAUD_DIV - 1);
   localparam logic [2:0]        LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic              HAS_PAR   = (PARITY_EN != 0);
   localparam logic              PAR_INV   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   tx_state_e             tx_state_q, tx_state_d;
   logic [TCNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [2:0]            tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0]  tx_hold_q, tx_hold_d;
   logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
   logic                  tx_out_q, tx_out_d;
   logic                  tx_empty_q, tx_empty_d;
   logic                  tx_bit_end;
   logic                  tx_par;

   assign tx_bit_end = (tx_cnt_q == '0);
   assign tx_par     = (^tx_hold_q) ^ PAR_INV;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_hold_d  = tx_hold_q;
      tx_shift_d = tx_shift_q;
      tx_out_d   = tx_out_q;
      tx_empty_d = tx_empty_q;

      if (ld_tx_data && tx_empty_q) begin
         tx_hold_d  = tx_data;
         tx_empty_d = 1'b0;
      end
      if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q - 1'b1;

      case (tx_state_q)
         TX_IDLE: begin
            tx_out_d = 1'b1;
            if (!tx_empty_q && tx_enable) begin
               tx_state_d = TX_START;
               tx_cnt_d   = TCNT_LAST;
               tx_shift_d = tx_hold_q;
               tx_out_d   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = TCNT_LAST;
               tx_idx_d   = 3'd0;
               tx_out_d   = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = TCNT_LAST;
               if (tx_idx_q == LAST_DATA) begin
                  tx_idx_d = 3'd0;
                  if (HAS_PAR) begin
                     tx_state_d = TX_PARITY;
                     tx_out_d   = tx_par;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_out_d   = 1'b1;
                  end
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_out_d   = tx_shift_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = TX_STOP;
               tx_cnt_d   = TCNT_LAST;
               tx_idx_d   = 3'd0;
               tx_out_d   = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d = TCNT_LAST;
               if (tx_idx_q == LAST_STOP) begin
                  tx_state_d = TX_IDLE;
                  tx_empty_d = 1'b1;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_hold_q  <= '0;
         tx_shift_q <= '0;
         tx_out_q   <= 1'b1;
         tx_empty_q <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_hold_q  <= tx_hold_d;
         tx_shift_q <= tx_shift_d;
         tx_out_q   <= tx_out_d;
         tx_empty_q <= tx_empty_d;
      end
   end

   assign tx_out   = tx_out_q;
   assign tx_empty = tx_empty_q;

   rx_state_e             rx_state_q, rx_state_d;
   logic                  rx_s1_q, rx_s2_q, rx_prev_q;
   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [3:0]            rx_tcnt_q, rx_tcnt_d;
   logic [2:0]            rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
   logic                  rx_par_q, rx_par_d;
   logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
   logic                  rx_empty_q, rx_empty_d;
   logic                  rx_ferr_q, rx_ferr_d;
   logic                  rx_perr_q, rx_perr_d;
   logic                  rx_ovr_q, rx_ovr_d;
   logic                  rx_tick;
   logic                  rx_sample;

   assign rx_tick   = (presc_q == '0);
   assign rx_sample = rx_tick && (rx_tcnt_q == 4'd0);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tcnt_d  = rx_tcnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_data_d  = rx_data_q;
      rx_empty_d = rx_empty_q;
      rx_ferr_d  = rx_ferr_q;
      rx_perr_d  = rx_perr_q;
      rx_ovr_d   = rx_ovr_q;
      presc_d    = rx_tick ? PRE_LAST : presc_q - 1'b1;

      if (uld_rx_data) begin
         rx_empty_d = 1'b1;
         rx_ferr_d  = 1'b0;
         rx_perr_d  = 1'b0;
         rx_ovr_d   = 1'b0;
      end
      if (rx_tick && rx_tcnt_q != 4'd0) rx_tcnt_d = rx_tcnt_q - 4'd1;

      if (!rx_enable) begin
         rx_state_d = RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               // edge detect also keeps a line stuck low after a frame error from re-arming
               if (rx_prev_q && !rx_s2_q) begin
                  rx_state_d = RX_START;
                  rx_tcnt_d  = 4'd7;
               end
            end
            RX_START: begin
               if (rx_sample) begin
                  if (rx_s2_q) begin
                     rx_state_d = RX_IDLE;
                  end else begin
                     rx_state_d = RX_DATA;
                     rx_tcnt_d  = 4'd15;
                     rx_idx_d   = 3'd0;
                  end
               end
            end
            RX_DATA: begin
               if (rx_sample) begin
                  rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                  rx_tcnt_d  = 4'd15;
                  if (rx_idx_q == LAST_DATA) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                  else rx_idx_d = rx_idx_q + 3'd1;
               end
            end
            RX_PARITY: begin
               if (rx_sample) begin
                  rx_par_d   = rx_s2_q;
                  rx_state_d = RX_STOP;
                  rx_tcnt_d  = 4'd15;
               end
            end
            RX_STOP: begin
               // a completing frame overrides a same-cycle unload
               if (rx_sample) begin
                  rx_data_d  = rx_shift_q;
                  rx_empty_d = 1'b0;
                  rx_ferr_d  = !rx_s2_q;
                  rx_perr_d  = HAS_PAR && (rx_par_q != ((^rx_shift_q) ^ PAR_INV));
                  rx_ovr_d   = !rx_empty_q && !uld_rx_data;
                  rx_state_d = RX_IDLE;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         presc_q    <= PRE_LAST;
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_empty_q <= 1'b1;
         rx_ferr_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_s1_q    <= rx_in;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         presc_q    <= presc_d;
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_empty_q <= rx_empty_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_perr_q  <= rx_perr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_empty      = rx_empty_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: dut_a is 8N1 (loopback capable), dut_b is 8E2; both BAUD_DIV=4.
// Expected RX words are queued when a frame is driven and popped when the DUT delivers it.
module tb_uart_param;

   localparam int BIT = 64;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
      logic       ovr;
   } rx_exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ld_a = 1'b0, ld_b = 1'b0;
   logic [7:0] txd_a = '0, txd_b = '0;
   logic       txen_a = 1'b1, txen_b = 1'b1;
   logic       txo_a, txo_b, txe_a, txe_b;
   logic       uld_a = 1'b0, uld_b = 1'b0;
   logic       rxen_a = 1'b1, rxen_b = 1'b1;
   logic       rxi_a, rxi_b;
   logic [7:0] rxd_a, rxd_b;
   logic       rxe_a, rxe_b, ferr_a, ferr_b, perr_a, perr_b, ovr_a, ovr_b;
   logic       a_loop = 1'b0;
   logic       sel_b = 1'b0;
   logic       rx_drv = 1'b1;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   rx_exp_t    sb_a[$];
   rx_exp_t    sb_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rxi_a = a_loop ? txo_a : (sel_b ? 1'b1 : rx_drv);
   assign rxi_b = sel_b ? rx_drv : 1'b1;

   uart_param #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(rst_n), .ld_tx_data(ld_a), .tx_data(txd_a), .tx_enable(txen_a),
      .tx_out(txo_a), .tx_empty(txe_a), .uld_rx_data(uld_a), .rx_enable(rxen_a), .rx_in(rxi_a),
      .rx_data(rxd_a), .rx_empty(rxe_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
      .rx_overrun(ovr_a)
   );

   uart_param #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(rst_n), .ld_tx_data(ld_b), .tx_data(txd_b), .tx_enable(txen_b),
      .tx_out(txo_b), .tx_empty(txe_b), .uld_rx_data(uld_b), .rx_enable(rxen_b), .rx_in(rxi_b),
      .rx_data(rxd_b), .rx_empty(rxe_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
      .rx_overrun(ovr_b)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rx_exp_t mk(input logic [7:0] d, input logic f, input logic p, input logic o);
      return {d, f, p, o};
   endfunction

   task automatic tx_load(input bit b, input logic [7:0] d);
      @(negedge clk);
      if (b) begin txd_b = d; ld_b = 1'b1; end
      else   begin txd_a = d; ld_a = 1'b1; end
      @(negedge clk);
      ld_a = 1'b0;
      ld_b = 1'b0;
   endtask

   task automatic wait_txe(input bit b, input string tag);
      int n;
      n = 0;
      while (!(b ? txe_b : txe_a) && n < 1000) begin @(negedge clk); n++; end
      chk_eq(tag, b ? txe_b : txe_a, 1'b1);
   endtask

   task automatic rx_check(input bit b, input string tag);
      rx_exp_t e;
      int n;
      n = 0;
      while ((b ? rxe_b : rxe_a) && n < 2000) begin @(negedge clk); n++; end
      chk_eq({tag, "_empty"}, b ? rxe_b : rxe_a, 1'b0);
      if ((b ? sb_b.size() : sb_a.size()) == 0) begin
         chk_eq({tag, "_sb_size"}, 0, 1);
      end else begin
         e = b ? sb_b.pop_front() : sb_a.pop_front();
         chk_eq({tag, "_data"}, b ? rxd_b : rxd_a, e.data);
         chk_eq({tag, "_ferr"}, b ? ferr_b : ferr_a, e.ferr);
         chk_eq({tag, "_perr"}, b ? perr_b : perr_a, e.perr);
         chk_eq({tag, "_ovr"},  b ? ovr_b : ovr_a, e.ovr);
      end
   endtask

   task automatic unload(input bit b, input string tag);
      @(negedge clk);
      if (b) uld_b = 1'b1; else uld_a = 1'b1;
      @(negedge clk);
      uld_a = 1'b0;
      uld_b = 1'b0;
      chk_eq({tag, "_empty"}, b ? rxe_b : rxe_a, 1'b1);
      chk_eq({tag, "_flags"}, b ? {ferr_b, perr_b, ovr_b} : {ferr_a, perr_a, ovr_a}, 3'b000);
   endtask

   // Drives bits LSB first, one bit period each, starting on a fixed prescaler phase.
   // seen = first cycle index after which rx_data equals watch.
   task automatic send_raw(input logic [15:0] bits, input int nb, input int uld_at,
                           input int en_off_at, input logic [7:0] watch, output int seen);
      seen = -1;
      while (cyc % 4 != 0) @(negedge clk);
      for (int i = 0; i < nb * BIT; i++) begin
         rx_drv = bits[i / BIT];
         if (sel_b) uld_b = (i == uld_at); else uld_a = (i == uld_at);
         if (i == en_off_at) begin
            if (sel_b) rxen_b = 1'b0; else rxen_a = 1'b0;
         end
         @(negedge clk);
         if (seen < 0 && (sel_b ? rxd_b : rxd_a) == watch) seen = i;
      end
      rx_drv = 1'b1;
      uld_a  = 1'b0;
      uld_b  = 1'b0;
      rxen_a = 1'b1;
      rxen_b = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cnt[10];
      logic [9:0] fr;
      int         first, n, s_ovr, dummy, zeros;

      repeat (3) @(negedge clk);
      chk_eq("rst_txo_a", txo_a, 1'b1);
      chk_eq("rst_txe_a", txe_a, 1'b1);
      chk_eq("rst_rxd_a", rxd_a, 8'h00);
      chk_eq("rst_rxe_a", rxe_a, 1'b1);
      chk_eq("rst_flags_a", {ferr_a, perr_a, ovr_a}, 3'b000);
      chk_eq("rst_tx_b", {txo_b, txe_b, rxe_b}, 3'b111);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 transmit of 0xA5, looped back into dut_a's receiver
      a_loop = 1'b1;
      fr = {1'b1, 8'hA5, 1'b0};
      foreach (cnt[k]) cnt[k] = 0;
      sb_a.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
      tx_load(0, 8'hA5);
      chk_eq("tx_pre_start", txo_a, 1'b1);
      chk_eq("tx_busy", txe_a, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 10 * BIT; i++) begin
         if (txo_a == fr[i / BIT]) cnt[i / BIT]++;
         if (i == 10 * BIT - 1) chk_eq("tx_empty_last", txe_a, 1'b0);
         @(negedge clk);
      end
      chk_eq("tx_empty_rise", txe_a, 1'b1);
      for (int k = 0; k < 10; k++) chk_eq($sformatf("tx_bit%0d_clks", k), cnt[k], BIT);
      rx_check(0, "lb_a5");
      unload(0, "uld_a5");

      // loopback 0x3C then 0xFF
      sb_a.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
      sb_a.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0));
      tx_load(0, 8'h3C);
      rx_check(0, "lb_3c");
      unload(0, "uld_3c");
      wait_txe(0, "lb_txe1");
      tx_load(0, 8'hFF);
      rx_check(0, "lb_ff");
      unload(0, "uld_ff");
      wait_txe(0, "lb_txe2");
      a_loop = 1'b0;

      // even parity transmit on dut_b: 0x07 has three ones -> parity 1, two stop bits
      tx_load(1, 8'h07);
      n = 0;
      while (txo_b && n < 20) begin @(negedge clk); n++; end
      chk_eq("b_start", txo_b, 1'b0);
      first = -1;
      for (int i = 0; i < 800; i++) begin
         if (i == 8 * BIT + 32) chk_eq("b_d7", txo_b, 1'b0);
         if (i == 9 * BIT + 32) chk_eq("b_parity", txo_b, 1'b1);
         if (i == 10 * BIT + 32) chk_eq("b_stop1", txo_b, 1'b1);
         if (i == 11 * BIT + 32) chk_eq("b_stop2", txo_b, 1'b1);
         if (first < 0 && txe_b) first = i;
         @(negedge clk);
      end
      chk_eq("b_frame_len", first, 12 * BIT);

      // parity receive on dut_b
      sel_b = 1'b1;
      sb_b.push_back(mk(8'h07, 1'b0, 1'b1, 1'b0));
      send_raw({4'b0000, 2'b11, 1'b0, 8'h07, 1'b0}, 12, -1, -1, 8'h00, dummy);
      rx_check(1, "b_bad_par");
      unload(1, "b_uld_perr");
      sb_b.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
      send_raw({4'b0000, 2'b11, 1'b1, 8'h07, 1'b0}, 12, -1, -1, 8'h00, dummy);
      rx_check(1, "b_good_par");
      unload(1, "b_uld_ok");
      sb_b.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
      send_raw({4'b0000, 2'b11, 1'b0, 8'hC3, 1'b0}, 12, -1, -1, 8'h00, dummy);
      rx_check(1, "b_c3");
      unload(1, "b_uld_c3");
      sel_b = 1'b0;

      // frame error: stop bit low
      sb_a.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0));
      send_raw({6'b0, 1'b0, 8'h55, 1'b0}, 10, -1, -1, 8'h00, dummy);
      rx_check(0, "ferr");
      unload(0, "uld_ferr");

      // 12-clk glitch must be rejected
      while (cyc % 4 != 0) @(negedge clk);
      rx_drv = 1'b0;
      repeat (12) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      chk_eq("glitch_empty", rxe_a, 1'b1);

      // overrun, and unload coinciding with completion
      sb_a.push_back(mk(8'h33, 1'b0, 1'b0, 1'b0));
      send_raw({6'b0, 1'b1, 8'h33, 1'b0}, 10, -1, -1, 8'h00, dummy);
      rx_check(0, "ovr_w1");
      sb_a.push_back(mk(8'h44, 1'b0, 1'b0, 1'b1));
      send_raw({6'b0, 1'b1, 8'h44, 1'b0}, 10, -1, -1, 8'h44, s_ovr);
      rx_check(0, "ovr_w2");
      unload(0, "uld_ovr");
      sb_a.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
      send_raw({6'b0, 1'b1, 8'h55, 1'b0}, 10, -1, -1, 8'h00, dummy);
      rx_check(0, "sim_w1");
      sb_a.push_back(mk(8'h66, 1'b0, 1'b0, 1'b0));
      send_raw({6'b0, 1'b1, 8'h66, 1'b0}, 10, s_ovr, -1, 8'h00, dummy);
      rx_check(0, "sim_w2");
      unload(0, "uld_sim");

      // rx_enable dropped mid-frame discards it
      send_raw({6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, 4 * BIT, 8'h00, dummy);
      repeat (100) @(negedge clk);
      chk_eq("rxen_abort_empty", rxe_a, 1'b1);

      // asynchronous reset mid-frame, then tx_enable gating
      tx_load(0, 8'h00);
      repeat (20) @(negedge clk);
      chk_eq("tx_pre_rst", txo_a, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("arst_txo", txo_a, 1'b1);
      chk_eq("arst_txe", txe_a, 1'b1);
      chk_eq("arst_rxd", rxd_a, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      txen_a = 1'b0;
      tx_load(0, 8'h81);
      zeros = 0;
      repeat (50) begin
         if (!txo_a) zeros++;
         @(negedge clk);
      end
      chk_eq("gated_no_start", zeros, 0);
      chk_eq("gated_busy", txe_a, 1'b0);
      txen_a = 1'b1;
      @(negedge clk);
      chk_eq("gated_start", txo_a, 1'b0);
      wait_txe(0, "gated_done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
